tty_serial_receiver: RTL and testbench

- Teletype-style asynchronous serial receiver for the PDP-8/I keyboard/reader path.
- Consumes the 8x-baud square wave from the variable-clock module: its div[0] output, J2.
- Deserializes start/data/stop frames on the serial line into a parallel character.
- Presents the character with a sticky done flag, framing error and overrun status to the keyboard-interface logic (KSF/KCC/KRB).

---
 rtl/tty_serial_receiver.sv | 100 ++++++++++
 tb/tb_tty_serial_receiver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tty_serial_receiver.sv
// tty_serial_receiver: 8x-oversampled async serial receiver with sticky done/framing/overrun status.
module tty_serial_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk8x,
  input  logic                 rx,
  input  logic                 clear_flag,
  output logic [DATA_BITS-1:0] data,
  output logic                 flag,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLE) + 1;
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam bit STOP_CHK = STOP_BITS > 0;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
  state_t               state_q;
  logic [2:0]           c8_q;
  logic [1:0]           rx_q;
  logic [TW-1:0]        tcnt_q;
  logic [BW-1:0]        bcnt_q;
  logic [DATA_BITS-1:0] sh_q, data_q;
  logic                 flag_q, fe_q, ov_q;
  logic                 tick, rx_s, samp;
  // c8_q[1] is the synchronized clk8x; c8_q[2] delays it one clk for edge detection
  assign tick = c8_q[1] & ~c8_q[2];
  assign rx_s = rx_q[1];
  assign samp = tcnt_q == TW'(OVERSAMPLE - 1);
  assign busy = state_q != S_IDLE;
  assign data = data_q;
  assign flag = flag_q;
  assign framing_err = fe_q;
  assign overrun = ov_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      c8_q    <= '1;
      rx_q    <= '1;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      c8_q <= {c8_q[1:0], clk8x};
      rx_q <= {rx_q[0], rx};
      if (clear_flag) begin
        flag_q <= 1'b0;
        fe_q   <= 1'b0;
        ov_q   <= 1'b0;
      end
      if (tick) begin
        case (state_q)
          S_IDLE: if (!rx_s) begin
            state_q <= S_START;
            tcnt_q  <= TW'(1);
          end
          S_START: begin
            tcnt_q <= tcnt_q + TW'(1);
            if (tcnt_q == TW'(OVERSAMPLE / 2)) begin
              state_q <= rx_s ? S_IDLE : S_DATA;
              tcnt_q  <= '0;
              bcnt_q  <= '0;
            end
          end
          S_DATA: begin
            tcnt_q <= tcnt_q + TW'(1);
            if (samp) begin
              sh_q   <= {rx_s, sh_q[DATA_BITS-1:1]};
              tcnt_q <= '0;
              bcnt_q <= bcnt_q + BW'(1);
              if (bcnt_q == BW'(DATA_BITS - 1)) state_q <= S_STOP;
            end
          end
          S_STOP: begin
            tcnt_q <= tcnt_q + TW'(1);
            // a completed frame overrides a coincident clear_flag
            if (samp) begin
              data_q  <= sh_q;
              flag_q  <= 1'b1;
              fe_q    <= STOP_CHK & ~rx_s;
              ov_q    <= flag_q | (ov_q & ~clear_flag);
              tcnt_q  <= '0;
              state_q <= rx_s ? S_IDLE : S_BREAK;
            end
          end
          S_BREAK: if (rx_s) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tty_serial_receiver.sv
// tb_tty_serial_receiver: directed frames with a scoreboard queue checked by a completion monitor.
`timescale 1ns/1ps
module tb_tty_serial_receiver;
  logic       clk = 1'b0, reset = 1'b1, clk8x = 1'b0, rx = 1'b1, clear_flag = 1'b0;
  logic [7:0] data;
  logic       flag, framing_err, overrun, busy;
  int         checks = 0, errors = 0;
  typedef struct {logic [7:0] d; logic fe, ov, bz;} exp_t;
  exp_t       sb[$];
  exp_t       e;
  logic       pf = 1'b0, pb = 1'b0;

  tty_serial_receiver dut (
    .clk(clk), .reset(reset), .clk8x(clk8x), .rx(rx), .clear_flag(clear_flag),
    .data(data), .flag(flag), .framing_err(framing_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always #80 clk8x = ~clk8x;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic ov, input logic bz);
    exp_t x;
    x.d = d; x.fe = fe; x.ov = ov; x.bz = bz;
    sb.push_back(x);
  endtask

  task automatic align();
    @(posedge clk8x);
    #40;
  endtask

  task automatic send(input logic [7:0] v, input logic stop);
    rx = 1'b0;
    #1280;
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      #1280;
    end
    rx = stop;
    #1280;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_flag = 1'b1;
    @(negedge clk);
    clear_flag = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, 16'(data), 16'h0);
    chk({tag, "_flag"}, 16'(flag), 16'h0);
    chk({tag, "_ferr"}, 16'(framing_err), 16'h0);
    chk({tag, "_ovr"}, 16'(overrun), 16'h0);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
  endtask

  // a frame completes when flag rises, or when busy drops while flag was already set
  always @(negedge clk) begin
    if (!reset && ((flag && !pf) || (!busy && pb && flag && pf))) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got data=%h expected no frame at %0t", data, $time);
      end else begin
        e = sb.pop_front();
        chk("mon_data", 16'(data), 16'(e.d));
        chk("mon_ferr", 16'(framing_err), 16'(e.fe));
        chk("mon_ovr", 16'(overrun), 16'(e.ov));
        chk("mon_busy", 16'(busy), 16'(e.bz));
      end
    end
    pf = flag;
    pb = busy;
  end

  initial begin
    #20;
    chk_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    #640;
    // 1: 0x55, flag rises exactly at the stop-sample edge
    push(8'h55, 1'b0, 1'b0, 1'b0);
    align();
    fork
      send(8'h55, 1'b1);
      begin
        #12300;
        chk("t1_flag_before", 16'(flag), 16'h0);
        #10;
        chk("t1_flag_after", 16'(flag), 16'h1);
      end
    join
    pulse_clear();
    // 2: 0xA3 then clear; data persists
    push(8'hA3, 1'b0, 1'b0, 1'b0);
    align();
    send(8'hA3, 1'b1);
    chk("t2_flag_set", 16'(flag), 16'h1);
    pulse_clear();
    chk("t2_flag_clr", 16'(flag), 16'h0);
    chk("t2_data_kept", 16'(data), 16'hA3);
    chk("t2_ferr", 16'(framing_err), 16'h0);
    chk("t2_ovr", 16'(overrun), 16'h0);
    // 3: two-tick glitch is a false start
    align();
    rx = 1'b0;
    #320;
    rx = 1'b1;
    #80;
    chk("t3_busy_start", 16'(busy), 16'h1);
    #560;
    chk("t3_busy_idle", 16'(busy), 16'h0);
    chk("t3_flag", 16'(flag), 16'h0);
    // 4: framing error then held break
    push(8'h0F, 1'b1, 1'b0, 1'b1);
    align();
    send(8'h0F, 1'b0);
    #3840;
    chk("t4_busy_break", 16'(busy), 16'h1);
    pulse_clear();
    chk("t4_flag_clr", 16'(flag), 16'h0);
    chk("t4_ferr_clr", 16'(framing_err), 16'h0);
    rx = 1'b1;
    #800;
    chk("t4_busy_idle", 16'(busy), 16'h0);
    // 5: back-to-back frames, clear coincident with the second stop sample
    push(8'h41, 1'b0, 1'b0, 1'b0);
    push(8'h42, 1'b0, 1'b1, 1'b0);
    align();
    send(8'h41, 1'b1);
    fork
      send(8'h42, 1'b1);
      begin
        #12300;
        clear_flag = 1'b1;
        #10;
        clear_flag = 1'b0;
      end
    join
    chk("t5_flag", 16'(flag), 16'h1);
    chk("t5_ovr", 16'(overrun), 16'h1);
    chk("t5_data", 16'(data), 16'h42);
    // 6: reset mid-frame, then a clean frame
    align();
    rx = 1'b0;
    #1280;
    for (int i = 0; i < 4; i++) begin
      rx = (8'h7E >> i) & 8'h01 ? 1'b1 : 1'b0;
      #1280;
    end
    rx = 1'b1;
    #640;
    reset = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    #99;
    reset = 1'b0;
    #2560;
    chk("t6_flag_none", 16'(flag), 16'h0);
    chk("t6_busy_none", 16'(busy), 16'h0);
    push(8'h33, 1'b0, 1'b0, 1'b0);
    align();
    send(8'h33, 1'b1);
    #2560;
    chk("sb_empty", 16'(sb.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
